// File: rtl/gray_counter.sv
// gray_counter: registered binary count with glitch-free Gray image; define GRAY_DOWN_EN to add the up/down direction port
module gray_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_DOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);
    logic [WIDTH-1:0] step_bin;
    logic             boundary;
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;
    // one count step and whether it crosses the modulo boundary
`ifdef GRAY_DOWN_EN
    always_comb begin
        step_bin = up ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
        boundary = up ? &bin_out : ~|bin_out;
    end
`else
    always_comb begin
        step_bin = bin_out + WIDTH'(1);
        boundary = &bin_out;
    end
`endif
    // load beats en; wrap only on a real step across the boundary
    always_comb begin
        next_bin  = load ? load_bin : en ? step_bin : bin_out;
        next_wrap = !load && en && boundary;
    end
    // Gray is derived from next_bin so both registers update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= next_bin ^ (next_bin >> 1);
            wrap     <= next_wrap;
        end
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and random checks of gray_counter against an arithmetic reference model
module tb_gray_counter;
    localparam int WIDTH = 8;
    localparam int MOD   = 256;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_bin = '0;
    logic             up = 1'b1;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;
    int n_checks = 0;
    int n_fail = 0;
    int mb = 0;
    int mw = 0;
    logic [WIDTH-1:0] prev_gray;
    int gseq [16] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                      8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .load_bin(load_bin),
`ifdef GRAY_DOWN_EN
        .up(up),
`endif
        .bin_out(bin_out),
        .gray_out(gray_out),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int b);
        return b ^ (b / 2);
    endfunction

    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] lb, input logic u);
        logic eff_up;
        logic stepped;
`ifdef GRAY_DOWN_EN
        eff_up = u;
`else
        eff_up = 1'b1;
`endif
        rst = r; load = l; en = e; load_bin = lb; up = u;
        prev_gray = gray_out;
        @(posedge clk);
        stepped = !r && !l && e;
        if (r) begin mb = 0; mw = 0; end
        else if (l) begin mb = int'(lb); mw = 0; end
        else if (e && eff_up) begin mw = (mb == MOD - 1) ? 1 : 0; mb = (mb + 1) % MOD; end
        else if (e) begin mw = (mb == 0) ? 1 : 0; mb = (mb + MOD - 1) % MOD; end
        else mw = 0;
        #1;
        chk("bin", 32'(bin_out), 32'(mb));
        chk("gray", 32'(gray_out), 32'(gray_of(mb)));
        chk("wrap", 32'(wrap), 32'(mw));
        if (stepped) chk("one_bit_change", 32'($countones(gray_out ^ prev_gray)), 32'd1);
    endtask

    initial begin
        cycle(1, 1, 1, 8'h5A, 1);
        cycle(1, 1, 1, 8'hC3, 1);
        chk("reset_bin", 32'(bin_out), 32'h00);
        chk("reset_gray", 32'(gray_out), 32'h00);
        chk("reset_wrap", 32'(wrap), 32'h0);
        cycle(0, 0, 0, 8'h00, 1);
        chk("seq_start", 32'(gray_out), 32'(gseq[0]));
        for (int i = 1; i < 16; i++) begin
            cycle(0, 0, 1, 8'h00, 1);
            chk("seq_table", 32'(gray_out), 32'(gseq[i]));
        end
        cycle(0, 1, 0, 8'hFF, 1);
        chk("load_ff_gray", 32'(gray_out), 32'h80);
        cycle(0, 0, 1, 8'h00, 1);
        chk("wrap_up_bin", 32'(bin_out), 32'h00);
        chk("wrap_up_gray", 32'(gray_out), 32'h00);
        chk("wrap_up_pulse", 32'(wrap), 32'h1);
        cycle(0, 0, 0, 8'h00, 1);
        chk("wrap_up_drop", 32'(wrap), 32'h0);
        cycle(0, 1, 1, 8'hA5, 1);
        chk("load_en_bin", 32'(bin_out), 32'hA5);
        chk("load_en_gray", 32'(gray_out), 32'hF7);
        chk("load_en_wrap", 32'(wrap), 32'h0);
        chk("gray_roundtrip", 32'(gray_decode(gray_out)), 32'hA5);
        cycle(0, 1, 0, 8'hFE, 1);
        cycle(0, 0, 1, 8'h00, 1);
        cycle(0, 0, 1, 8'h00, 1);
        chk("b2b_wrap", 32'(wrap), 32'h1);
        cycle(0, 0, 1, 8'h00, 1);
        chk("b2b_wrap_once", 32'(wrap), 32'h0);
`ifdef GRAY_DOWN_EN
        cycle(1, 0, 0, 8'h00, 1);
        cycle(0, 0, 1, 8'h00, 0);
        chk("down_bin", 32'(bin_out), 32'hFF);
        chk("down_gray", 32'(gray_out), 32'h80);
        chk("down_wrap", 32'(wrap), 32'h1);
        cycle(0, 0, 1, 8'h00, 0);
        chk("down2_bin", 32'(bin_out), 32'hFE);
        chk("down2_gray", 32'(gray_out), 32'h81);
        chk("down2_wrap", 32'(wrap), 32'h0);
`endif
        cycle(0, 1, 0, 8'h37, 1);
        cycle(1, 1, 1, 8'h99, 1);
        chk("midrst_bin", 32'(bin_out), 32'h00);
        chk("midrst_gray", 32'(gray_out), 32'h00);
        chk("midrst_wrap", 32'(wrap), 32'h0);
        cycle(0, 0, 1, 8'h00, 1);
        chk("resume_bin", 32'(bin_out), 32'h01);
        chk("resume_gray", 32'(gray_out), 32'h01);
        for (int i = 0; i < 600; i++) begin
            logic [WIDTH-1:0] lb;
            lb = (i % 97 == 0) ? 8'hFF : ((i % 89 == 0) ? 8'h00 : 8'($urandom));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  lb, ($urandom_range(0, 2) != 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
# gray_counter

Registered binary-to-Gray encoding counter: the inverse direction of the team's gray_binary decoder. Maintains a WIDTH-bit binary count and presents its Gray-code image from a register, so the Gray output changes exactly one bit per count step and is glitch-free. It is intended as the write/read pointer generator for clock-domain-crossing FIFOs and as a Gray stimulus source for gray_binary. Supports synchronous load, enable, wrap indication and an optional down-count mode.

## Interface
Parameters:
- WIDTH, 8: counter and code width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance the count by one step this cycle.
- load  input  1  load load_bin into the counter this cycle.
- load_bin  input  WIDTH  binary value for load.
- up  input  1  count direction, 1 = up, 0 = down. Present only with GRAY_DOWN_EN.
- bin_out  output  WIDTH  current binary count (registered).
- gray_out  output  WIDTH  Gray code of bin_out: bin_out ^ (bin_out >> 1) (registered, no combinational path from inputs).
- wrap  output  1  one-cycle pulse, the cycle after a step crosses the modulo boundary.

## Operation
- Internal state: binary count register b, Gray register g, wrap register.
- Per rising clk edge, priority rst > load > en:
  - rst: b = 0, g = 0, wrap = 0.
  - load: b = load_bin, g = load_bin ^ (load_bin >> 1), wrap = 0. en ignored.
  - en (up): b = b + 1 mod 2^WIDTH; wrap = 1 iff old b was all ones.
  - en (down, macro only): b = b - 1 mod 2^WIDTH; wrap = 1 iff old b was 0.
  - idle: b, g hold; wrap = 0.
- g is computed from next-b and registered in the same edge as b; gray_out and bin_out are always mutually consistent.
- Arithmetic is unsigned, WIDTH bits, with silent modulo wrap-around; no saturation.
- Invariant: on every en step, gray_out changes in exactly one bit position. On load, any number of bits may change.

## Timing
- Reset values: bin_out = 0, gray_out = 0, wrap = 0.
- Latency: en/load sampled at edge N; bin_out, gray_out, wrap reflect the result after edge N (one cycle).
- wrap high for exactly one cycle per boundary crossing; back-to-back en across the boundary produces one pulse per crossing.
- Reset asserted mid-count overrides load and en in the same cycle; counting resumes from 0 on the first en after rst deasserts.
- load and en together: load wins, no step applied, wrap = 0.
- Direction change (macro): up sampled with en in the same cycle; reversing takes effect on that step with no extra latency.

## Configuration
- GRAY_DOWN_EN defined: up port exists; en with up = 0 decrements, wrap fires on 0 -> all-ones.
- GRAY_DOWN_EN undefined: no up port; counter is up-only; all down-count logic absent.

## Test plan
- Reset: hold rst 2 cycles with en = 1, load = 1 -> bin_out = 8'h00, gray_out = 8'h00, wrap = 0 throughout.
- Count from 0 with en = 1 for 16 cycles -> gray_out sequence 00,01,03,02,06,07,05,04,0C,0D,0F,0E,0A,0B,09,08; one-bit-change check on every step.
- Load 8'hFF then en -> after load gray_out = 8'h80; next edge bin_out = 8'h00, gray_out = 8'h00, wrap = 1 for one cycle only.
- load = 1 with load_bin = 8'hA5 and en = 1 same cycle -> bin_out = 8'hA5, gray_out = 8'hF7, wrap = 0; feeding gray_out into gray_binary returns 8'hA5.
- GRAY_DOWN_EN: from reset, up = 0, en = 1 -> bin_out = 8'hFF, gray_out = 8'h80, wrap = 1; next step bin_out = 8'hFE, gray_out = 8'h81, wrap = 0.
- rst asserted mid-count at bin_out = 8'h37 -> next edge all outputs 0; release rst, one en -> bin_out = 8'h01, gray_out = 8'h01.
